// File: rtl/priority_event_encoder.sv
// priority_event_encoder: sticky per-source event capture with fixed-priority or
// round-robin grant of one pending index per cycle over a valid/ready output.
module priority_event_encoder #(
    parameter int N       = 8,
    parameter bit RR_MODE = 1'b0,
    parameter int IDXW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_in,
    input  logic [N-1:0]    mask,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [IDXW-1:0] out_idx,
    output logic [N-1:0]    pending,
    output logic            overflow,
    output logic            busy
);
    logic [N-1:0]    set_vec, elig, clr_vec;
    logic [IDXW-1:0] rr_ptr, base, cand, winner;
    logic            load, grant;
    assign set_vec = req_in & mask;
    assign elig    = pending & mask;
    assign load    = ~out_valid | out_ready;
    assign grant   = load & (|elig);
    assign base    = RR_MODE ? rr_ptr : '0;
    assign clr_vec = grant ? (N'(1) << winner) : '0;
    assign busy    = out_valid | (|pending);
    // Walk from base (lowest) up to base-1 (highest) so the last hit is base-1 downward.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IDXW'((int'(base) + N - k) % N);
            if (elig[cand]) winner = cand;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            overflow  <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            pending  <= (pending & ~clr_vec) | set_vec;
            overflow <= |(set_vec & pending & ~clr_vec);
            if (load) out_valid <= grant;
            if (grant) begin
                out_idx <= winner;
                rr_ptr  <= RR_MODE ? winner : rr_ptr;
            end
        end
    end
endmodule

// File: tb/tb_priority_event_encoder.sv
// tb_priority_event_encoder: fixed and round-robin encoders driven in lockstep and
// checked against hand tables, directed sequences and a distance-ordered reference model.
module tb_priority_event_encoder;
    logic       clk = 1'b0, rst_n = 1'b1;
    logic [7:0] req = '0, mask = 8'hFF;
    logic       rdy = 1'b1;
    logic       f_valid, f_ovf, f_busy, r_valid, r_ovf, r_busy;
    logic [2:0] f_idx, r_idx;
    logic [7:0] f_pend, r_pend;
    int         n_cmp = 0, n_bad = 0;
    logic [7:0] mp [2];
    bit         mv [2], mo [2];
    int         mi [2], mptr [2];
    typedef struct {
        logic [7:0] req, mask;
        logic       rdy;
        int         rep;
        logic       v;
        logic [2:0] idx;
        logic [7:0] pend;
        logic       ovf;
    } vec_t;
    vec_t tbl [$];

    always #5 clk = ~clk;

    priority_event_encoder #(.N(8), .RR_MODE(1'b0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req_in(req), .mask(mask), .out_ready(rdy),
        .out_valid(f_valid), .out_idx(f_idx), .pending(f_pend), .overflow(f_ovf), .busy(f_busy));
    priority_event_encoder #(.N(8), .RR_MODE(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req_in(req), .mask(mask), .out_ready(rdy),
        .out_valid(r_valid), .out_idx(r_idx), .pending(r_pend), .overflow(r_ovf), .busy(r_busy));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mp[m] = '0; mv[m] = 0; mo[m] = 0; mi[m] = 0; mptr[m] = 0;
        end
    endtask

    // Winner = eligible source at smallest descending distance from the pointer (pointer itself last).
    task automatic model_step();
        logic [7:0] np;
        bit         load, keep, set;
        int         win, best, d;
        for (int m = 0; m < 2; m++) begin
            load = !mv[m] || rdy;
            win  = -1;
            best = 99;
            for (int i = 0; i < 8; i++) begin
                d = (mptr[m] - i + 8) % 8;
                if (d == 0) d = 8;
                if (mp[m][i] && mask[i] && d < best) begin best = d; win = i; end
            end
            if (!load) win = -1;
            mo[m] = 0;
            for (int i = 0; i < 8; i++) begin
                keep = mp[m][i] && (i != win);
                set  = req[i] && mask[i];
                if (set && keep) mo[m] = 1;
                np[i] = set || keep;
            end
            mp[m] = np;
            if (load) mv[m] = (win >= 0);
            if (win >= 0) begin
                mi[m] = win;
                if (m == 1) mptr[m] = win;
            end
        end
    endtask

    task automatic check_model();
        chk("fix_valid", f_valid, mv[0]);
        chk("fix_idx",   f_idx,   mi[0]);
        chk("fix_pend",  f_pend,  mp[0]);
        chk("fix_ovf",   f_ovf,   mo[0]);
        chk("fix_busy",  f_busy,  mv[0] | (|mp[0]));
        chk("rr_valid",  r_valid, mv[1]);
        chk("rr_idx",    r_idx,   mi[1]);
        chk("rr_pend",   r_pend,  mp[1]);
        chk("rr_ovf",    r_ovf,   mo[1]);
        chk("rr_busy",   r_busy,  mv[1] | (|mp[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        req = '0;
        #2 rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic add(input logic [7:0] rq, input logic [7:0] mk, input logic rd, input int rep,
                       input logic v, input logic [2:0] ix, input logic [7:0] pd, input logic ov);
        vec_t e;
        e.req = rq; e.mask = mk; e.rdy = rd; e.rep = rep;
        e.v = v; e.idx = ix; e.pend = pd; e.ovf = ov;
        tbl.push_back(e);
    endtask

    initial begin
        add(8'h00, 8'hFF, 1, 1,  0, 0, 8'h00, 0);
        add(8'h24, 8'hFF, 1, 1,  0, 0, 8'h24, 0);
        add(8'h00, 8'hFF, 1, 1,  1, 5, 8'h04, 0);
        add(8'h00, 8'hFF, 1, 1,  1, 2, 8'h00, 0);
        add(8'h00, 8'hFF, 1, 1,  0, 2, 8'h00, 0);
        add(8'h81, 8'hFF, 0, 1,  0, 2, 8'h81, 0);
        add(8'h00, 8'hFF, 0, 1,  1, 7, 8'h01, 0);
        add(8'h00, 8'hFF, 0, 10, 1, 7, 8'h01, 0);
        add(8'h00, 8'hFF, 1, 1,  1, 0, 8'h00, 0);
        add(8'h00, 8'hFF, 1, 1,  0, 0, 8'h00, 0);
        add(8'h08, 8'hFF, 0, 1,  0, 0, 8'h08, 0);
        add(8'h00, 8'hFF, 0, 1,  1, 3, 8'h00, 0);
        add(8'h02, 8'hFF, 0, 1,  1, 3, 8'h02, 0);
        add(8'h02, 8'hFF, 0, 1,  1, 3, 8'h02, 1);
        add(8'h00, 8'hFF, 0, 1,  1, 3, 8'h02, 0);
        add(8'h08, 8'hFF, 0, 1,  1, 3, 8'h0A, 0);
        add(8'h00, 8'hFF, 1, 1,  1, 3, 8'h02, 0);
        add(8'h00, 8'hFF, 1, 1,  1, 1, 8'h00, 0);
        add(8'h00, 8'hFF, 1, 1,  0, 1, 8'h00, 0);
        add(8'hF0, 8'h0F, 1, 1,  0, 1, 8'h00, 0);
        add(8'h00, 8'h0F, 1, 1,  0, 1, 8'h00, 0);
        add(8'h40, 8'hFF, 1, 1,  0, 1, 8'h40, 0);
        add(8'h40, 8'hBF, 1, 3,  0, 1, 8'h40, 0);
        add(8'h00, 8'hFF, 1, 1,  1, 6, 8'h00, 0);
        add(8'h00, 8'hFF, 1, 1,  0, 6, 8'h00, 0);

        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", f_valid, 0);
        chk("rst_idx",   f_idx,   0);
        chk("rst_pend",  f_pend,  0);
        chk("rst_ovf",   f_ovf,   0);
        chk("rst_busy",  r_busy,  0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[t]) begin
            for (int r = 0; r < tbl[t].rep; r++) begin
                req = tbl[t].req; mask = tbl[t].mask; rdy = tbl[t].rdy;
                tick();
                chk($sformatf("tbl%0d_valid", t), f_valid, tbl[t].v);
                chk($sformatf("tbl%0d_idx", t),   f_idx,   tbl[t].idx);
                chk($sformatf("tbl%0d_pend", t),  f_pend,  tbl[t].pend);
                chk($sformatf("tbl%0d_ovf", t),   f_ovf,   tbl[t].ovf);
                chk($sformatf("tbl%0d_busy", t),  f_busy,  tbl[t].v | (|tbl[t].pend));
            end
        end

        // Round-robin rotation under continuous requests.
        do_reset();
        mask = 8'hFF; rdy = 1'b1; req = 8'hFF;
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rr_rot_valid", r_valid, 1);
            chk("rr_rot_idx",   r_idx,   ((7 - k) % 8 + 8) % 8);
            chk("rr_rot_ovf",   r_ovf,   1);
            chk("fix_hold7",    f_idx,   7);
        end
        req = '0;
        repeat (10) tick();

        // Asynchronous reset while busy.
        do_reset();
        rdy = 1'b0; req = 8'h80;
        tick();
        req = 8'h00;
        tick();
        req = 8'h5A;
        tick();
        req = 8'h00;
        chk("pre_rst_pend",  f_pend,  8'h5A);
        chk("pre_rst_valid", f_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", f_valid, 0);
        chk("async_pend",  f_pend,  0);
        chk("async_busy",  f_busy,  0);
        chk("async_rr_busy", r_busy, 0);
        chk("async_rr_idx",  r_idx,  0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_valid", f_valid | r_valid, 0);
            chk("post_rst_busy",  f_busy | r_busy,   0);
        end

        // Randomised traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            req  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            mask = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFF;
            rdy  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
